// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the ryuki core debug/trace path.
//
// trace_output      : one completed trace record as produced by trace_unit.
//                     Field order puts pc in the least significant word, so
//                     memory word 0 of a stored record is the pc.
// trace_store_state_t: states of the trace store controller FSM.
// TRACE_BITS        : width of a trace record in bits.
// TRACE_WORD_BYTES  : byte stride between consecutive memory words.
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] info;
        logic [31:0] result;
        logic [31:0] instr;
        logic [31:0] pc;
    } trace_output;

    localparam int TRACE_BITS       = $bits(trace_output);
    localparam int TRACE_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_REQ,
        TS_WAIT
    } trace_store_state_t;

endpackage

// File: rtl/trace_store_controller_fifo.sv
// trace_record_fifo: synchronous FIFO of trace records.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers only)
//   push       enqueue data_in (ignored when full unless pop frees a slot,
//              and ignored while flush is asserted)
//   pop        dequeue the head entry (ignored when empty)
//   flush      discard queued entries
//   keep_head  with flush: the head entry is in use and survives the flush
//   data_in    record to enqueue
//   head       current head record
//   full/empty occupancy flags
//   count      number of entries held
module trace_record_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic                        keep_head,
    input  logic [TRACE_BITS-1:0]       data_in,
    output logic [TRACE_BITS-1:0]       head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [TRACE_BITS-1:0] storage [DEPTH];
    logic [PW:0] rd_ptr;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_next;
    logic        do_pop;
    logic        do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW + 1)'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees an entry, so a push into a full FIFO is
    // still accepted when the head leaves.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rd_next = do_pop ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= rd_next;
            // Keep exactly the head entry if it is still in use and not leaving now.
            if (keep_head && !do_pop && !empty) begin
                wr_ptr <= rd_ptr + PTR_ONE;
            end else begin
                wr_ptr <= rd_next;
            end
        end else begin
            rd_ptr <= rd_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[PW-1:0]] <= data_in;
        end
    end

    assign head = storage[rd_ptr[PW-1:0]];

endmodule

// File: rtl/trace_store_controller.sv
// trace_store_controller: drains trace records from trace_unit into a
// circular buffer in data memory, one 32-bit word write at a time.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable_i          accept new records when 1
//   flush_i           discard queued records that have not started writing
//   trace_data_ready  single-cycle record-valid pulse
//   trace_data_i      record payload
//   mem_req_o/we_o    write request (we always equals req)
//   mem_addr_o        byte address of the word being written
//   mem_wdata_o       word being written
//   mem_gnt_i         request accepted
//   mem_rvalid_i      write completed
//   busy_o            work in progress or queued
//   wrapped_o         sticky: slot pointer has wrapped
//   slot_ptr_o        next slot to be written
//   dropped_o         records lost because the queue was full (saturating)
module trace_store_controller
    import ryuki_datatypes::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    RECORD_WORDS    = 4,
    parameter int                    QUEUE_DEPTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] TRACE_BASE_ADDR = 'h0001_0000,
    parameter int                    TRACE_SLOTS     = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic                           flush_i,
    input  logic                           trace_data_ready,
    input  logic [TRACE_BITS-1:0]          trace_data_i,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    output logic                           busy_o,
    output logic                           wrapped_o,
    output logic [$clog2(TRACE_SLOTS)-1:0] slot_ptr_o,
    output logic [15:0]                    dropped_o
);

    localparam int SLOT_W      = $clog2(TRACE_SLOTS);
    localparam int WORD_W      = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
    localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1;
    localparam int RECORD_BITS = RECORD_WORDS * DATA_WIDTH;

    trace_store_state_t state;
    trace_store_state_t state_next;

    logic [WORD_W-1:0]      word_idx;
    logic [SLOT_W-1:0]      slot_ptr;
    logic                   wrapped;
    logic [15:0]            dropped;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [TRACE_BITS-1:0]  head;
    logic [RECORD_BITS-1:0] record_bits;
    logic [DATA_WIDTH-1:0]  word_data;
    logic [ADDR_WIDTH-1:0]  word_offset;

    logic push_req;
    logic last_word;
    logic word_done;
    logic pop;
    logic drop_event;

    assign push_req   = trace_data_ready & enable_i;
    assign last_word  = (word_idx == WORD_W'(RECORD_WORDS - 1));
    assign word_done  = (state == TS_WAIT) & mem_rvalid_i;
    assign pop        = word_done & last_word;
    // Flushed pushes are discarded on purpose and are not drops.
    assign drop_event = push_req & fifo_full & ~pop & ~flush_i;

    trace_record_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .pop      (pop),
        .flush    (flush_i),
        .keep_head(state != TS_IDLE),
        .data_in  (trace_data_i),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The head record stays in the FIFO until its last word completes, so a
    // flush can never tear a record that has started writing.
    always_comb begin
        state_next = state;
        case (state)
            TS_IDLE: begin
                if (!fifo_empty && !flush_i) begin
                    state_next = TS_REQ;
                end
            end
            TS_REQ: begin
                if (mem_gnt_i) begin
                    state_next = TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (mem_rvalid_i) begin
                    if (!last_word) begin
                        state_next = TS_REQ;
                    end else if ((fifo_count > CNT_W'(1)) && !flush_i) begin
                        state_next = TS_REQ;
                    end else begin
                        state_next = TS_IDLE;
                    end
                end
            end
            default: state_next = TS_IDLE;
        endcase
    end

    // Word select from the head record, zero-padded if the record is narrower.
    always_comb begin
        record_bits = RECORD_BITS'(head);
        word_data   = '0;
        for (int i = 0; i < RECORD_WORDS; i++) begin
            if (word_idx == WORD_W'(i)) begin
                word_data = record_bits[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Address and data are driven only while requesting so idle and reset
    // both present zero; they are held stable through a stalled grant
    // because word_idx and slot_ptr only move on completion.
    always_comb begin
        word_offset = ADDR_WIDTH'(slot_ptr) * ADDR_WIDTH'(RECORD_WORDS) + ADDR_WIDTH'(word_idx);
        mem_req_o   = (state == TS_REQ);
        mem_we_o    = (state == TS_REQ);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state == TS_REQ) begin
            mem_addr_o  = TRACE_BASE_ADDR + word_offset * ADDR_WIDTH'(TRACE_WORD_BYTES);
            mem_wdata_o = word_data;
        end
    end

    // Word serialiser, slot pointer, wrap flag and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            slot_ptr <= '0;
            wrapped  <= 1'b0;
            dropped  <= '0;
        end else begin
            if (word_done) begin
                word_idx <= last_word ? '0 : word_idx + WORD_W'(1);
            end
            if (pop) begin
                if (slot_ptr == SLOT_W'(TRACE_SLOTS - 1)) begin
                    slot_ptr <= '0;
                    wrapped  <= 1'b1;
                end else begin
                    slot_ptr <= slot_ptr + SLOT_W'(1);
                end
            end
            if (drop_event && (dropped != 16'hFFFF)) begin
                dropped <= dropped + 16'd1;
            end
        end
    end

    assign busy_o     = (state != TS_IDLE) | ~fifo_empty;
    assign wrapped_o  = wrapped;
    assign slot_ptr_o = slot_ptr;
    assign dropped_o  = dropped;

endmodule

// File: tb/tb_trace_store_controller.sv
// Directed testbench for trace_store_controller with a small memory responder
// that grants requests (optionally stalled or delayed on one address),
// completes each write one cycle after grant, and logs every granted write.
module tb_trace_store_controller;

    logic         clk;
    logic         rst;
    logic         enable_i;
    logic         flush_i;
    logic         trace_data_ready;
    logic [127:0] trace_data_i;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic         busy_o;
    logic         wrapped_o;
    logic [7:0]   slot_ptr_o;
    logic [15:0]  dropped_o;

    int checks_total;
    int checks_passed;
    int checks_failed;

    // Memory responder configuration and observation state.
    logic        mem_stall;
    logic [31:0] delay_addr;
    int          delay_left;
    int          hold_cycles;
    logic        data_moved;
    logic [31:0] first_data;
    logic        rvalid_pending;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    trace_store_controller dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .trace_data_ready(trace_data_ready),
        .trace_data_i    (trace_data_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .busy_o          (busy_o),
        .wrapped_o       (wrapped_o),
        .slot_ptr_o      (slot_ptr_o),
        .dropped_o       (dropped_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder acts on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        mem_rvalid_i = 1'b0;
        if (rvalid_pending) begin
            mem_rvalid_i   = 1'b1;
            rvalid_pending = 1'b0;
        end
        mem_gnt_i = 1'b0;
        if (!rst && mem_req_o && !mem_stall) begin
            if (mem_addr_o == delay_addr) begin
                if (hold_cycles == 0) first_data = mem_wdata_o;
                else if (mem_wdata_o !== first_data) data_moved = 1'b1;
                hold_cycles++;
            end
            if (mem_addr_o == delay_addr && delay_left > 0) begin
                delay_left--;
            end else begin
                mem_gnt_i      = 1'b1;
                rvalid_pending = 1'b1;
                log_addr.push_back(mem_addr_o);
                log_data.push_back(mem_wdata_o);
            end
        end
    end

    function automatic logic [127:0] mkRec(input int k);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'hA000_0000 | (32'(k) << 8) | 32'(i);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Single-cycle record pulse.
    task automatic applyStimulus(input logic [127:0] rec);
        @(negedge clk);
        trace_data_ready = 1'b1;
        trace_data_i     = rec;
        @(negedge clk);
        trace_data_ready = 1'b0;
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        enable_i       = 1'b1;
        flush_i        = 1'b0;
        trace_data_ready = 1'b0;
        trace_data_i   = '0;
        mem_stall      = 1'b0;
        delay_addr     = 32'hFFFF_FFFF;
        delay_left     = 0;
        hold_cycles    = 0;
        data_moved     = 1'b0;
        rvalid_pending = 1'b0;
        log_addr.delete();
        log_data.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, " idle"}, busy_o, 1'b0);
    endtask

    task automatic waitReq(input string tag, input logic [31:0] addr);
        int n;
        n = 0;
        while (!(mem_req_o && mem_addr_o == addr) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, " req seen"}, mem_req_o && mem_addr_o == addr, 1'b1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;

        // Reset state.
        resetDut();
        #1;
        checkOutput("rst req",     mem_req_o,   1'b0);
        checkOutput("rst addr",    mem_addr_o,  32'h0);
        checkOutput("rst wdata",   mem_wdata_o, 32'h0);
        checkOutput("rst busy",    busy_o,      1'b0);
        checkOutput("rst slot",    slot_ptr_o,  8'd0);
        checkOutput("rst dropped", dropped_o,   16'd0);

        // 1: single record, immediate grant.
        applyStimulus(128'h00004444_00003333_00002222_00001111);
        checkOutput("t1 req after 1 cycle", mem_req_o, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t1 req after 2 cycles", mem_req_o, 1'b1);
        checkOutput("t1 we", mem_we_o, 1'b1);
        waitIdle("t1", 50);
        checkOutput("t1 writes", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("t1 addr%0d", i), log_addr[i], 32'h0001_0000 + 32'(i * 4));
                checkOutput($sformatf("t1 data%0d", i), log_data[i], 32'h1111 * 32'(i + 1));
            end
        end
        checkOutput("t1 slot", slot_ptr_o, 8'd1);

        // 2: grant delayed 3 cycles on word 2.
        resetDut();
        delay_addr = 32'h0001_0008;
        delay_left = 3;
        applyStimulus(mkRec(7));
        waitIdle("t2", 60);
        checkOutput("t2 req hold", hold_cycles, 4);
        checkOutput("t2 data stable", data_moved, 1'b0);
        checkOutput("t2 writes", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            checkOutput("t2 addr2", log_addr[2], 32'h0001_0008);
            checkOutput("t2 data2", log_data[2], 32'hA000_0702);
            checkOutput("t2 addr3", log_addr[3], 32'h0001_000C);
        end

        // 3: six back-to-back pulses into a stalled memory.
        resetDut();
        mem_stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            trace_data_ready = 1'b1;
            trace_data_i     = mkRec(k);
        end
        @(negedge clk);
        trace_data_ready = 1'b0;
        checkOutput("t3 dropped", dropped_o, 16'd2);
        checkOutput("t3 busy", busy_o, 1'b1);
        mem_stall = 1'b0;
        waitIdle("t3", 200);
        checkOutput("t3 writes", log_addr.size(), 16);
        if (log_addr.size() == 16) begin
            for (int r = 0; r < 4; r++) begin
                checkOutput($sformatf("t3 rec%0d addr", r), log_addr[r*4], 32'h0001_0000 + 32'(r * 16));
                checkOutput($sformatf("t3 rec%0d data", r), log_data[r*4+3], 32'hA000_0003 | (32'(r) << 8));
            end
        end
        checkOutput("t3 slot", slot_ptr_o, 8'd4);

        // 5: flush while word 1 of the head is in flight, with a push in the same cycle.
        resetDut();
        delay_addr = 32'h0001_0004;
        delay_left = 5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            trace_data_ready = 1'b1;
            trace_data_i     = mkRec(k + 1);
        end
        @(negedge clk);
        trace_data_ready = 1'b0;
        waitReq("t5", 32'h0001_0004);
        @(negedge clk);
        flush_i          = 1'b1;
        trace_data_ready = 1'b1;
        trace_data_i     = mkRec(9);
        @(negedge clk);
        flush_i          = 1'b0;
        trace_data_ready = 1'b0;
        waitIdle("t5", 60);
        checkOutput("t5 writes", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            checkOutput("t5 last data", log_data[3], 32'hA000_0103);
        end
        checkOutput("t5 dropped", dropped_o, 16'd0);
        checkOutput("t5 slot", slot_ptr_o, 8'd1);

        // 4: fill slots up to 255, then two records straddle the wrap.
        resetDut();
        for (int k = 0; k < 255; k++) begin
            applyStimulus(mkRec(k & 8'hFF));
            waitIdle("t4 fill", 50);
        end
        checkOutput("t4 slot at 255", slot_ptr_o, 8'd255);
        checkOutput("t4 not wrapped", wrapped_o, 1'b0);
        log_addr.delete();
        log_data.delete();
        applyStimulus(mkRec(1));
        applyStimulus(mkRec(2));
        waitIdle("t4", 100);
        checkOutput("t4 writes", log_addr.size(), 8);
        if (log_addr.size() == 8) begin
            checkOutput("t4 slot255 addr", log_addr[0], 32'h0001_0FF0);
            checkOutput("t4 wrap addr", log_addr[4], 32'h0001_0000);
            checkOutput("t4 wrap data", log_data[4], 32'hA000_0200);
        end
        checkOutput("t4 wrapped", wrapped_o, 1'b1);
        checkOutput("t4 slot", slot_ptr_o, 8'd1);

        // 6: asynchronous reset while a request is outstanding.
        mem_stall = 1'b1;
        applyStimulus(mkRec(5));
        waitReq("t6", 32'h0001_0010);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6 req", mem_req_o, 1'b0);
        checkOutput("t6 we", mem_we_o, 1'b0);
        checkOutput("t6 addr", mem_addr_o, 32'h0);
        checkOutput("t6 wdata", mem_wdata_o, 32'h0);
        checkOutput("t6 busy", busy_o, 1'b0);
        checkOutput("t6 wrapped", wrapped_o, 1'b0);
        checkOutput("t6 slot", slot_ptr_o, 8'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_stall = 1'b0;
        log_addr.delete();
        repeat (5) @(negedge clk);
        checkOutput("t6 abandoned busy", busy_o, 1'b0);
        checkOutput("t6 abandoned writes", log_addr.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
